mod_carga_matriz_5x5: RTL and testbench
=======================================

MOD_CARGA_MATRIZ_5X5 -- requirements
Module: mod_carga_matriz_5x5

Interface
REQ-001 SHALL have parameter TIMEOUT, 1023, maximum cycles to wait for det_done after start_det.
REQ-002 SHALL have parameter TAM_MAX, 5, matrix order of the downstream determinant unit.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 tamanho  in  3  matrix order N (2..5), sampled on the first accepted element of a load.
REQ-006 dado_in  in  8  signed element, row-major, element (0,0) first.
REQ-007 dado_valido  in  1  dado_in valid.
REQ-008 dado_pronto  out  1  block can accept an element.
REQ-009 matriz  out  200  25 signed 8-bit elements a..y; element r*5+c at bits [8*(r*5+c)+7 : 8*(r*5+c)].
REQ-010 start_det  out  1  one-cycle start pulse to the 5x5 determinant unit.
REQ-011 det_done  in  1  done level from the determinant unit.
REQ-012 det_resultado  in  16  signed determinant from the determinant unit.
REQ-013 resultado  out  16  latched signed determinant.
REQ-014 resultado_valido  out  1  one-cycle pulse when resultado updates.
REQ-015 ocupado  out  1  high in any state other than OCIOSO.
REQ-016 erro  out  1  sticky timeout / illegal-size flag.

Function
REQ-017 SHALL implement the states OCIOSO, CARGA, DISPARO, ESPERA.
REQ-018 Transfer SHALL occur only on a cycle with dado_valido && dado_pronto high.
REQ-019 dado_pronto SHALL be high in OCIOSO and CARGA, and low in DISPARO and ESPERA.
REQ-020 OCIOSO: on transfer, SHALL latch tamanho, store the element at (0,0), set count=1, and go to CARGA (or to DISPARO when N*N==1 is impossible; N>=2).
REQ-021 CARGA: element k SHALL be stored at row k/N, column k%N of the 5x5 grid.
REQ-022 After the N*N-th transfer, the state SHALL become DISPARO on the next edge.
REQ-023 Positions outside the NxN top-left block SHALL hold identity padding: 1 on the diagonal and 0 elsewhere, so that det5x5 equals detNxN.
REQ-024 Padding SHALL be written when the load begins, so matriz is stable and fully defined during DISPARO and ESPERA.
REQ-025 DISPARO SHALL assert start_det for exactly one cycle, clear the timeout counter, and go to ESPERA.
REQ-026 ESPERA SHALL detect a rising edge of det_done (det_done high, previous sample low).
REQ-027 On that edge, ESPERA SHALL latch det_resultado into resultado, pulse resultado_valido, and go to OCIOSO.
REQ-028 If det_done is already high on entry to ESPERA, the block SHALL still wait for a fresh rising edge.
REQ-029 If the counter reaches TIMEOUT in ESPERA, the block SHALL set erro, leave resultado unchanged, and go to OCIOSO.
REQ-030 If tamanho is <2 or >5 at the first transfer, the block SHALL set erro, discard the element, and stay in OCIOSO.
REQ-031 erro SHALL clear only on rst or on the first transfer of a new legal load.
REQ-032 matriz SHALL hold its last value in OCIOSO until the next load starts.

Reset
REQ-033 rst SHALL force the state to OCIOSO.
REQ-034 rst SHALL clear the count, the timeout counter, start_det, resultado_valido, ocupado and erro.
REQ-035 rst SHALL set resultado = 0, load matriz with the 5x5 identity, and set dado_pronto = 1 on the cycle after rst.
REQ-036 rst asserted mid-load or in ESPERA SHALL abandon the operation with no resultado_valido pulse.

Configuration
REQ-037 With ORDEM_COLUNA_EN defined, element k SHALL go to row k%N, column k/N (column-major input).
REQ-038 With ORDEM_COLUNA_EN defined, the determinant SHALL be unchanged; without it, input is row-major per REQ-021.

Structure
REQ-039 Package pkg_matriz SHALL hold the state encoding, TAM_MAX, element width 8, result width 16, and the element index helper.
REQ-040 One sub-module, mod_timeout_cnt (counter with clear, enable, terminal flag), SHALL be instantiated for ESPERA.

Verification
REQ-041 N=5, elements 1..25 row-major, model det_done after 40 cycles returning 0 -> one start_det pulse, resultado=0, resultado_valido pulse.
REQ-042 N=2, elements 3,8,4,6 -> matriz has 3,8 / 4,6 top-left and identity elsewhere; model returns -14 -> resultado=-14.
REQ-043 N=5, dado_valido toggling every other cycle -> exactly 25 transfers counted, no element lost or duplicated.
REQ-044 det_done never rises -> erro=1 exactly TIMEOUT cycles after start_det, no resultado_valido pulse, ocupado=0.
REQ-045 tamanho=6 on the first element -> erro=1, state OCIOSO; then a legal N=3 load -> erro cleared, normal result.
REQ-046 rst during CARGA at element 12 -> next cycle ocupado=0, matriz=identity; a new full load completes correctly.

Source files
------------

// File: rtl/mod_carga_matriz_5x5_pkg.sv
// Shared definitions for the 5x5 matrix loader: state encoding, sizes,
// element position helper and the identity constant used as padding.
package pkg_matriz;

  localparam int TAM_MAX = 5;
  localparam int ELEM_W  = 8;
  localparam int RES_W   = 16;
  localparam int MAT_W   = TAM_MAX * TAM_MAX * ELEM_W;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARGA   = 2'd1,
    DISPARO = 2'd2,
    ESPERA  = 2'd3
  } estado_t;

  // Flat 5x5 position of an element given its slow and fast load indices.
  // Row-major: slow index is the row. Column-major: slow index is the column.
  function automatic logic [4:0] elem_idx(input logic [2:0] lento,
                                          input logic [2:0] rapido,
                                          input logic       col_major);
    logic [4:0] r;
    logic [4:0] c;
    if (col_major) begin
      r = {2'b00, rapido};
      c = {2'b00, lento};
    end else begin
      r = {2'b00, lento};
      c = {2'b00, rapido};
    end
    return (r * 5'd5) + c;
  endfunction

  // 5x5 identity: padding that makes det5x5 equal to det of the loaded NxN block.
  function automatic logic [MAT_W-1:0] identidade();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < TAM_MAX; i++) begin
      m[ELEM_W*i*(TAM_MAX+1) +: ELEM_W] = ELEM_W'(1);
    end
    return m;
  endfunction

endpackage

// File: rtl/mod_carga_matriz_5x5_timeout_cnt.sv
// Saturating cycle counter with synchronous clear and enable. term_o flags
// the cycle in which the counter sits at TERM while enabled.
module mod_timeout_cnt #(
  parameter int             W    = 10,
  parameter logic [W-1:0]   TERM = '1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [W-1:0] cnt_q;

  // Count enabled cycles, holding at TERM; clear has priority over enable.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != TERM)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign term_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/mod_carga_matriz_5x5.sv
// Loads an NxN signed matrix (N = 2..5) into a 5x5 identity-padded grid,
// fires the downstream 5x5 determinant unit and latches its result.
// Optional build macro ORDEM_COLUNA_EN: elements arrive column-major
// instead of row-major (the determinant is unaffected).
//
// Input handshake: an element transfers on a rising clock edge where both
// dado_valido and dado_pronto are high; dado_valido may be driven freely,
// and dado_pronto depends only on the state register, never on dado_valido.
module mod_carga_matriz_5x5 #(
  parameter int TIMEOUT = 1023,
  parameter int TAM_MAX = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [2:0]                              tamanho,
  input  logic signed [pkg_matriz::ELEM_W-1:0]    dado_in,
  input  logic                                    dado_valido,
  output logic                                    dado_pronto,
  output logic [pkg_matriz::MAT_W-1:0]            matriz,
  output logic                                    start_det,
  input  logic                                    det_done,
  input  logic signed [pkg_matriz::RES_W-1:0]     det_resultado,
  output logic signed [pkg_matriz::RES_W-1:0]     resultado,
  output logic                                    resultado_valido,
  output logic                                    ocupado,
  output logic                                    erro,
  output logic [1:0]                              estado_dbg
);

  import pkg_matriz::*;

  localparam int                CNT_W     = $clog2(TIMEOUT + 1);
  // ESPERA starts one cycle after start_det with the counter at 0, so
  // stopping at TIMEOUT-2 puts erro up exactly TIMEOUT cycles after start_det.
  localparam logic [CNT_W-1:0]  TO_TERM   = CNT_W'(TIMEOUT - 2);
  localparam logic [2:0]        TAM_MAX_L = 3'(TAM_MAX);
  localparam logic [MAT_W-1:0]  IDENT     = identidade();
`ifdef ORDEM_COLUNA_EN
  localparam logic              COL_MAJOR = 1'b1;
`else
  localparam logic              COL_MAJOR = 1'b0;
`endif

  estado_t                 estado_q;
  logic [2:0]              n_q;
  logic [4:0]              cont_q;
  logic [2:0]              lento_q;
  logic [2:0]              rapido_q;
  logic [MAT_W-1:0]        matriz_q;
  logic signed [RES_W-1:0] resultado_q;
  logic                    resultado_valido_q;
  logic                    start_det_q;
  logic                    erro_q;
  logic                    det_done_ant_q;

  logic                    transf;
  logic                    tam_ok;
  logic                    ultimo;
  logic                    borda_done;
  logic                    to_term;
  logic [5:0]              total_n;
  logic [4:0]              pos;

  assign transf     = dado_valido && dado_pronto;
  assign tam_ok     = (tamanho >= 3'd2) && (tamanho <= TAM_MAX_L);
  assign total_n    = {3'b000, n_q} * {3'b000, n_q};
  assign ultimo     = ({1'b0, cont_q} + 6'd1) == total_n;
  assign pos        = elem_idx(lento_q, rapido_q, COL_MAJOR);
  assign borda_done = det_done && !det_done_ant_q;

  mod_timeout_cnt #(
    .W    (CNT_W),
    .TERM (TO_TERM)
  ) u_timeout (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (estado_q == DISPARO),
    .en_i   (estado_q == ESPERA),
    .term_o (to_term)
  );

  // Main controller: load sequencing, start pulse, result/timeout handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q           <= OCIOSO;
      n_q                <= 3'd0;
      cont_q             <= 5'd0;
      lento_q            <= 3'd0;
      rapido_q           <= 3'd0;
      matriz_q           <= IDENT;
      resultado_q        <= '0;
      resultado_valido_q <= 1'b0;
      start_det_q        <= 1'b0;
      erro_q             <= 1'b0;
      det_done_ant_q     <= 1'b0;
    end else begin
      start_det_q        <= 1'b0;
      resultado_valido_q <= 1'b0;
      det_done_ant_q     <= det_done;
      case (estado_q)
        OCIOSO: begin
          if (transf) begin
            if (tam_ok) begin
              // Padding goes in with the first element so the whole grid
              // is defined by the time the determinant unit looks at it.
              erro_q   <= 1'b0;
              n_q      <= tamanho;
              matriz_q <= {IDENT[MAT_W-1:ELEM_W], dado_in};
              cont_q   <= 5'd1;
              lento_q  <= 3'd0;
              rapido_q <= 3'd1;
              estado_q <= CARGA;
            end else begin
              erro_q <= 1'b1;
            end
          end
        end
        CARGA: begin
          if (transf) begin
            matriz_q[ELEM_W*pos +: ELEM_W] <= dado_in;
            cont_q <= cont_q + 5'd1;
            if (rapido_q == (n_q - 3'd1)) begin
              rapido_q <= 3'd0;
              lento_q  <= lento_q + 3'd1;
            end else begin
              rapido_q <= rapido_q + 3'd1;
            end
            if (ultimo) begin
              estado_q    <= DISPARO;
              start_det_q <= 1'b1;
            end
          end
        end
        DISPARO: begin
          estado_q <= ESPERA;
        end
        ESPERA: begin
          // A done level left over from before ESPERA is not an edge.
          if (borda_done) begin
            resultado_q        <= det_resultado;
            resultado_valido_q <= 1'b1;
            estado_q           <= OCIOSO;
          end else if (to_term) begin
            erro_q   <= 1'b1;
            estado_q <= OCIOSO;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign dado_pronto      = (estado_q == OCIOSO) || (estado_q == CARGA);
  assign ocupado          = (estado_q != OCIOSO);
  assign matriz           = matriz_q;
  assign start_det        = start_det_q;
  assign resultado        = resultado_q;
  assign resultado_valido = resultado_valido_q;
  assign erro             = erro_q;
  assign estado_dbg       = estado_q;

endmodule

// File: tb/tb_mod_carga_matriz_5x5.sv
// Directed bench for mod_carga_matriz_5x5 with a behavioural determinant
// unit and a result scoreboard.
module tb_mod_carga_matriz_5x5;
  import pkg_matriz::*;

  localparam int TIMEOUT = 1023;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   tamanho;
  logic [7:0]   dado_in;
  logic         dado_valido;
  logic         dado_pronto;
  logic [199:0] matriz;
  logic         start_det;
  logic         det_done;
  logic [15:0]  det_resultado;
  logic [15:0]  resultado;
  logic         resultado_valido;
  logic         ocupado;
  logic         erro;
  logic [1:0]   estado_dbg;

  always #5 clk = ~clk;

  mod_carga_matriz_5x5 #(.TIMEOUT(TIMEOUT), .TAM_MAX(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .tamanho          (tamanho),
    .dado_in          (dado_in),
    .dado_valido      (dado_valido),
    .dado_pronto      (dado_pronto),
    .matriz           (matriz),
    .start_det        (start_det),
    .det_done         (det_done),
    .det_resultado    (det_resultado),
    .resultado        (resultado),
    .resultado_valido (resultado_valido),
    .ocupado          (ocupado),
    .erro             (erro),
    .estado_dbg       (estado_dbg)
  );

  // ---------------- bookkeeping ----------------
  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_start  = 0;
  int           n_valid  = 0;
  logic [15:0]  exp_q[$];
  logic [7:0]   el[25];
  logic [199:0] ident;
  logic [199:0] m_ant;
  logic [15:0]  last_res;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference grid built from the bench's own element list.
  function automatic logic [199:0] mat_esp(input int n);
    logic [199:0] m;
    int r;
    int c;
    m = '0;
    for (int i = 0; i < 5; i++) m[8*(i*6) +: 8] = 8'd1;
    for (int k = 0; k < n*n; k++) begin
`ifdef ORDEM_COLUNA_EN
      r = k % n; c = k / n;
`else
      r = k / n; c = k % n;
`endif
      m[8*(r*5+c) +: 8] = el[k];
    end
    return m;
  endfunction

  // Exact integer determinant of a 5x5 grid (fraction-free elimination).
  function automatic longint det5(input logic [199:0] m);
    longint a[5][5];
    longint prev;
    longint t;
    longint sgn;
    int     p;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        a[i][j] = longint'($signed(m[8*(i*5+j) +: 8]));
    prev = 1;
    sgn  = 1;
    for (int k = 0; k < 4; k++) begin
      if (a[k][k] == 0) begin
        p = -1;
        for (int i = k + 1; i < 5; i++) if (p < 0 && a[i][k] != 0) p = i;
        if (p < 0) return 0;
        for (int j = 0; j < 5; j++) begin
          t = a[k][j]; a[k][j] = a[p][j]; a[p][j] = t;
        end
        sgn = -sgn;
      end
      for (int i = k + 1; i < 5; i++)
        for (int j = k + 1; j < 5; j++)
          a[i][j] = (a[i][j] * a[k][k] - a[i][k] * a[k][j]) / prev;
      prev = a[k][k];
    end
    return sgn * a[4][4];
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && start_det) n_start++;
    if (!rst && resultado_valido) begin
      n_valid++;
      if (exp_q.size() == 0) chk("valido_inesperado", resultado_valido, 200'd0);
      else chk("resultado", resultado, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic carregar(input int n, input int lim, input bit alterna);
    int k = 0;
    int ciclo = 0;
    tamanho = 3'(n);
    while (k < lim && ciclo < 400) begin
      @(negedge clk);
      ciclo++;
      dado_valido = alterna ? ciclo[0] : 1'b1;
      dado_in     = el[k];
      if (dado_valido && dado_pronto) k++;
    end
    @(negedge clk);
    dado_valido = 1'b0;
    chk("carga_transf", k, lim);
  endtask

  task automatic esperar_start();
    int i = 0;
    while (!start_det && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("start_det", start_det, 200'd1);
  endtask

  // Behavioural determinant unit: answers with det of what it sees on matriz.
  task automatic responder(input int atraso, input bit baixar);
    int i = 0;
    repeat (atraso) @(negedge clk);
    det_resultado = 16'(det5(matriz));
    det_done      = 1'b1;
    while (ocupado && i < 10) begin
      @(negedge clk);
      i++;
    end
    chk("fim_ocupado", ocupado, 200'd0);
    @(negedge clk);
    if (baixar) det_done = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s0;
    int v0;
    int i;
    ident = '0;
    for (int k = 0; k < 5; k++) ident[8*(k*6) +: 8] = 8'd1;
    rst = 1'b1; tamanho = 3'd0; dado_in = 8'd0; dado_valido = 1'b0;
    det_done = 1'b0; det_resultado = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_ocupado", ocupado, 200'd0);
    chk("rst_pronto", dado_pronto, 200'd1);
    chk("rst_erro", erro, 200'd0);
    chk("rst_resultado", resultado, 200'd0);
    chk("rst_matriz", matriz, ident);
    chk("rst_start", start_det, 200'd0);
    chk("rst_valido", resultado_valido, 200'd0);
    chk("rst_estado", estado_dbg, 200'(OCIOSO));

    // N=5, 1..25: singular matrix, slow determinant unit
    for (int k = 0; k < 25; k++) el[k] = 8'(k + 1);
    s0 = n_start; v0 = n_valid;
    carregar(5, 25, 1'b0);
    chk("t1_matriz", matriz, mat_esp(5));
    exp_q.push_back(16'(det5(mat_esp(5))));
    esperar_start();
    responder(40, 1'b1);
    chk("t1_n_start", n_start - s0, 200'd1);
    chk("t1_n_valid", n_valid - v0, 200'd1);
    chk("t1_res_zero", resultado, 200'd0);

    // N=2, 3 8 / 4 6: padding and negative result; leave det_done high
    el[0] = 8'd3; el[1] = 8'd8; el[2] = 8'd4; el[3] = 8'd6;
    carregar(2, 4, 1'b0);
    chk("t2_matriz", matriz, mat_esp(2));
    exp_q.push_back(16'(det5(mat_esp(2))));
    esperar_start();
    responder(4, 1'b0);
    chk("t2_res_menos14", resultado, 200'(16'hFFF2));

    // N=5 with gaps in dado_valido; stale det_done level must not finish it
    for (int k = 0; k < 25; k++) el[k] = 8'(((k * 7) % 23) - 11);
    v0 = n_valid;
    carregar(5, 25, 1'b1);
    chk("t3_matriz", matriz, mat_esp(5));
    m_ant = mat_esp(5);
    exp_q.push_back(16'(det5(mat_esp(5))));
    esperar_start();
    repeat (10) @(negedge clk);
    chk("t3_nivel_alto_ocupado", ocupado, 200'd1);
    chk("t3_nivel_alto_sem_valido", n_valid - v0, 200'd0);
    det_done = 1'b0;
    responder(5, 1'b1);
    chk("t3_n_valid", n_valid - v0, 200'd1);

    // illegal size is rejected, then a legal N=3 load clears erro
    @(negedge clk);
    tamanho = 3'd6; dado_in = 8'h55; dado_valido = 1'b1;
    @(negedge clk);
    dado_valido = 1'b0;
    chk("t5_erro", erro, 200'd1);
    chk("t5_estado", estado_dbg, 200'(OCIOSO));
    chk("t5_ocupado", ocupado, 200'd0);
    chk("t5_matriz_mantida", matriz, m_ant);
    el[0] = 8'd2; el[1] = 8'd1; el[2] = 8'd0;
    el[3] = 8'd1; el[4] = 8'd3; el[5] = 8'd1;
    el[6] = 8'd0; el[7] = 8'd1; el[8] = 8'd4;
    carregar(3, 9, 1'b0);
    chk("t5_erro_limpo", erro, 200'd0);
    chk("t5_matriz", matriz, mat_esp(3));
    last_res = 16'(det5(mat_esp(3)));
    exp_q.push_back(last_res);
    esperar_start();
    responder(3, 1'b1);
    chk("t5_res_18", resultado, 200'd18);

    // determinant unit never answers: timeout
    for (int k = 0; k < 9; k++) el[k] = 8'($urandom_range(0, 40) - 20);
    v0 = n_valid;
    carregar(3, 9, 1'b0);
    chk("t4_matriz", matriz, mat_esp(3));
    esperar_start();
    i = 0;
    while (!erro && i < TIMEOUT + 5) begin
      @(negedge clk);
      i++;
    end
    chk("t4_ciclos_timeout", i, TIMEOUT);
    chk("t4_erro", erro, 200'd1);
    chk("t4_ocupado", ocupado, 200'd0);
    chk("t4_sem_valido", n_valid - v0, 200'd0);
    chk("t4_res_mantido", resultado, last_res);

    // reset in the middle of a load, then a clean full load
    for (int k = 0; k < 25; k++) el[k] = 8'($urandom_range(0, 40) - 20);
    v0 = n_valid;
    carregar(5, 12, 1'b0);
    chk("t6_em_carga", estado_dbg, 200'(CARGA));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_ocupado", ocupado, 200'd0);
    chk("t6_matriz_ident", matriz, ident);
    chk("t6_erro", erro, 200'd0);
    chk("t6_resultado", resultado, 200'd0);
    chk("t6_pronto", dado_pronto, 200'd1);
    chk("t6_sem_valido", n_valid - v0, 200'd0);
    for (int k = 0; k < 25; k++) el[k] = 8'($urandom_range(0, 40) - 20);
    carregar(5, 25, 1'b0);
    chk("t6_matriz", matriz, mat_esp(5));
    exp_q.push_back(16'(det5(mat_esp(5))));
    esperar_start();
    responder(7, 1'b1);

    // final scoreboard state
    chk("fila_vazia", exp_q.size(), 200'd0);
    chk("n_valid_total", n_valid, 200'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
